alu_issue: RTL

Single-thread issue/writeback sequencer that acts as the initiator for the combinational `alu` block. Accepts one decoded instruction at a time over a valid/ready handshake and reads source operands from an internal 16-entry register file. Drives the ALU opcode/operand bus, captures result and cmp_flag, then writes back to the register file or the compare flag. Sits between the warp scheduler/decoder and the ALU in each core lane.

---
 rtl/alu_issue.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for the combinational alu: IDLE -> READ -> EXEC -> WB.
// Optional retired-instruction counter enabled by defining ALU_ISSUE_PERF_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef OP_ADD
`define OP_ADD  4'h0
`define OP_SUB  4'h1
`define OP_MUL  4'h2
`define OP_CMP  4'h3
`define OP_ADDI 4'h4
`endif

module alu_issue #(
  parameter int NUM_REGS  = 16,
  parameter int IMM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [3:0]             instr_opcode,
  input  logic [3:0]             instr_rd,
  input  logic [3:0]             instr_rs,
  input  logic [3:0]             instr_rt,
  input  logic [IMM_WIDTH-1:0]   instr_imm,
  output logic [3:0]             alu_opcode,
  output logic [`DATA_WIDTH-1:0] alu_operand_a,
  output logic [`DATA_WIDTH-1:0] alu_operand_b,
  input  logic [`DATA_WIDTH-1:0] alu_result,
  input  logic                   alu_cmp_flag,
  output logic                   done,
  output logic                   illegal,
  output logic                   cmp_reg,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0]            retired_count,
`endif
  input  logic [3:0]             dbg_addr,
  output logic [`DATA_WIDTH-1:0] dbg_data
);

  localparam int DW = `DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           op_reg, rd_reg, rs_reg, rt_reg;
  logic [IMM_WIDTH-1:0] imm_reg;
  logic [DW-1:0]        result_reg;
  logic                 flag_reg;
  logic [DW-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_en;
  logic                 op_writes_rf;
  logic                 op_is_cmp;
  logic                 wb_write;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (instr_valid) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    op_writes_rf = (op_reg == `OP_ADD) || (op_reg == `OP_SUB) ||
                   (op_reg == `OP_MUL) || (op_reg == `OP_ADDI);
    op_is_cmp    = (op_reg == `OP_CMP);
    instr_ready  = (state_reg == S_IDLE);
    done         = (state_reg == S_WB);
    illegal      = (state_reg == S_WB) && !op_writes_rf && !op_is_cmp;
    wb_write     = (state_reg == S_WB) && op_writes_rf;
  end

  // Instruction latch, taken on the accepting handshake only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= '0;
      rd_reg  <= '0;
      rs_reg  <= '0;
      rt_reg  <= '0;
      imm_reg <= '0;
    end else if (instr_valid && instr_ready) begin
      op_reg  <= instr_opcode;
      rd_reg  <= instr_rd;
      rs_reg  <= instr_rs;
      rt_reg  <= instr_rt;
      imm_reg <= instr_imm;
    end
  end

  // ALU drive: updated only in READ, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode    <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
    end else if (state_reg == S_READ) begin
      alu_opcode    <= op_reg;
      alu_operand_a <= regs[rs_reg];
      if (op_reg == `OP_ADDI) begin
        alu_operand_b <= {{(DW-IMM_WIDTH){1'b0}}, imm_reg};
      end else begin
        alu_operand_b <= regs[rt_reg];
      end
    end
  end

  // Result capture at the end of EXEC, once the ALU has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      flag_reg   <= 1'b0;
    end else if (state_reg == S_EXEC) begin
      result_reg <= alu_result;
      flag_reg   <= alu_cmp_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_reg <= 1'b0;
    end else if ((state_reg == S_WB) && op_is_cmp) begin
      cmp_reg <= flag_reg;
    end
  end

  // Per-register write decode; entry 0 never gets an enable, so r0 stays zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
      if (gi == 0) begin : g_r0
        assign wr_en[gi] = 1'b0;
      end else begin : g_rn
        assign wr_en[gi] = wb_write && (rd_reg == 4'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= result_reg;
        end
      end
    end
  end

  assign dbg_data = (dbg_addr == 4'd0) ? '0 : regs[dbg_addr];

`ifdef ALU_ISSUE_PERF_EN
  // Counts every retire, illegal ones included; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (done) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule
